// File: rtl/spi_master_ctrl_if.sv
// Host register bus and SPI pin bundle for spi_master_ctrl.
// The controller takes the slave modport; the host/bench side takes master.
interface spi_master_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [7:0]            addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  we;
    logic                  re;
    logic                  irq;
    logic                  sck;
    logic                  mosi;
    logic                  miso;
    logic [4:0]            ss_n;

    modport master (
        output addr, wdata, we, re, miso,
        input  rdata, irq, sck, mosi, ss_n
    );

    modport slave (
        input  addr, wdata, we, re, miso,
        output rdata, irq, sck, mosi, ss_n
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Byte-wide SPI master behind the SPCR/SPSR/SPDR/PORTB register set.
// One byte is shifted per accepted SPDR write; SCK timing is latched at transfer start.
module spi_master_ctrl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter logic [7:0]  SPI_BASE_ADDR = 8'h00
) (
    input logic              clk,
    input logic              rst,
    spi_master_ctrl_if.slave bus
);
    localparam logic [7:0] AddrSpcr  = SPI_BASE_ADDR + 8'h00;
    localparam logic [7:0] AddrSpsr  = SPI_BASE_ADDR + 8'h10;
    localparam logic [7:0] AddrSpdr  = SPI_BASE_ADDR + 8'h20;
    localparam logic [7:0] AddrPortb = SPI_BASE_ADDR + 8'h40;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] spcr_q, spcr_d, portb_q, portb_d;
    logic [DATA_WIDTH-1:0] spdr_buf_q, spdr_buf_d, tx_q, tx_d, rx_q, rx_d;
    logic                  spif_q, spif_d, wcol_q, wcol_d, spi2x_q, spi2x_d;
    logic                  arm_q, arm_d, sck_q, sck_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d, dord_q, dord_d;
    logic [5:0]            hmax_q, hmax_d, hcnt_q, hcnt_d;
    logic [3:0]            ecnt_q, ecnt_d;

    logic sel_spcr, sel_spsr, sel_spdr, sel_portb;
    logic spdr_wr, spdr_acc, spsr_rd, abort, edge_sample, edge_shift;

    assign sel_spcr  = (bus.addr == AddrSpcr);
    assign sel_spsr  = (bus.addr == AddrSpsr);
    assign sel_spdr  = (bus.addr == AddrSpdr);
    assign sel_portb = (bus.addr == AddrPortb);
    assign spdr_wr   = bus.we && sel_spdr;
    assign spdr_acc  = (bus.we || bus.re) && sel_spdr;
    assign spsr_rd   = bus.re && sel_spsr;
    assign abort     = (state_q != StIdle) && !spcr_q[6];

    // Half-period length minus one, in clk cycles.
    function automatic logic [5:0] half_max(input logic [1:0] spr, input logic x2);
        logic [6:0] h;
        case (spr)
            2'b00:   h = 7'd2;
            2'b01:   h = 7'd8;
            2'b10:   h = 7'd32;
            default: h = 7'd64;
        endcase
        if (x2) h = h >> 1;
        return 6'(h - 7'd1);
    endfunction

    always_comb begin
        state_d     = state_q;
        spcr_d      = spcr_q;
        portb_d     = portb_q;
        spdr_buf_d  = spdr_buf_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        spif_d      = spif_q;
        wcol_d      = wcol_q;
        spi2x_d     = spi2x_q;
        arm_d       = arm_q;
        sck_d       = sck_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        dord_d      = dord_q;
        hmax_d      = hmax_q;
        hcnt_d      = hcnt_q;
        ecnt_d      = ecnt_q;
        edge_sample = 1'b0;
        edge_shift  = 1'b0;

        if (bus.we && sel_spcr)  spcr_d  = bus.wdata;
        if (bus.we && sel_spsr)  spi2x_d = bus.wdata[0];
        if (bus.we && sel_portb) portb_d = bus.wdata;

        if (spsr_rd && (spif_q || wcol_q)) arm_d = 1'b1;
        if (spdr_acc && arm_q) begin
            spif_d = 1'b0;
            wcol_d = 1'b0;
            arm_d  = 1'b0;
        end
        if (spdr_wr && (state_q != StIdle)) wcol_d = 1'b1;

        if (abort) begin
            state_d = StIdle;
            sck_d   = cpol_q;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sck_d = spcr_q[3];
                    if (spdr_wr && spcr_q[6]) begin
                        tx_d    = bus.wdata;
                        rx_d    = '0;
                        cpol_d  = spcr_q[3];
                        cpha_d  = spcr_q[2];
                        dord_d  = spcr_q[5];
                        hmax_d  = half_max(spcr_q[1:0], spi2x_q);
                        hcnt_d  = '0;
                        ecnt_d  = '0;
                        state_d = StLoad;
                    end
                end
                StLoad: begin
                    sck_d   = cpol_q;
                    state_d = StShift;
                end
                StShift: begin
                    if (hcnt_q == hmax_q) begin
                        hcnt_d = '0;
                        ecnt_d = ecnt_q + 4'd1;
                        sck_d  = ~sck_q;
                        // ecnt_q even means this is a leading edge
                        edge_sample = ~ecnt_q[0] ^ cpha_q;
                        edge_shift  = ~edge_sample && (ecnt_q != 4'd0);
                        if (edge_sample) begin
                            rx_d = dord_q ? {bus.miso, rx_q[DATA_WIDTH-1:1]}
                                          : {rx_q[DATA_WIDTH-2:0], bus.miso};
                        end
                        if (edge_shift) tx_d = dord_q ? (tx_q >> 1) : (tx_q << 1);
                        if (ecnt_q == 4'd15) begin
                            spdr_buf_d = rx_d;
                            spif_d     = 1'b1;
                            state_d    = StDone;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 6'd1;
                    end
                end
                StDone: begin
                    sck_d   = cpol_q;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            spcr_q     <= '0;
            portb_q    <= DATA_WIDTH'(8'h1F);
            spdr_buf_q <= DATA_WIDTH'(8'h20);
            tx_q       <= '0;
            rx_q       <= '0;
            spif_q     <= 1'b0;
            wcol_q     <= 1'b0;
            spi2x_q    <= 1'b0;
            arm_q      <= 1'b0;
            sck_q      <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            dord_q     <= 1'b0;
            hmax_q     <= '0;
            hcnt_q     <= '0;
            ecnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            spcr_q     <= spcr_d;
            portb_q    <= portb_d;
            spdr_buf_q <= spdr_buf_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            spif_q     <= spif_d;
            wcol_q     <= wcol_d;
            spi2x_q    <= spi2x_d;
            arm_q      <= arm_d;
            sck_q      <= sck_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            dord_q     <= dord_d;
            hmax_q     <= hmax_d;
            hcnt_q     <= hcnt_d;
            ecnt_q     <= ecnt_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (sel_spcr)       bus.rdata = spcr_q;
        else if (sel_spsr)  bus.rdata = DATA_WIDTH'({spif_q, wcol_q, 5'b01000, spi2x_q});
        else if (sel_spdr)  bus.rdata = spdr_buf_q;
        else if (sel_portb) bus.rdata = portb_q;
    end

    assign bus.irq  = spcr_q[7] & spif_q;
    assign bus.sck  = sck_q;
    assign bus.mosi = dord_q ? tx_q[0] : tx_q[DATA_WIDTH-1];
    assign bus.ss_n = portb_q[4:0];
endmodule
